// File: rtl/ex_shift_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// ex_shift_arbiter_if : two issue request ports plus the result port
// Rev 1.0
// ----------------------------------------------------------------------
interface ex_shift_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SH_W  = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [XLEN-1:0]  req0_src1;
  logic [XLEN-1:0]  req0_src2;
  logic [SH_W-1:0]  req0_shamt;
  logic             req0_shamt_en;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [XLEN-1:0]  req1_src1;
  logic [XLEN-1:0]  req1_src2;
  logic [SH_W-1:0]  req1_shamt;
  logic             req1_shamt_en;
  logic [TAG_W-1:0] req1_tag;

  logic             res_valid;
  logic             res_ready;
  logic [XLEN-1:0]  res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_src;

  modport master (
    output req0_valid, req0_op, req0_src1, req0_src2, req0_shamt, req0_shamt_en, req0_tag,
    input  req0_ready,
    output req1_valid, req1_op, req1_src1, req1_src2, req1_shamt, req1_shamt_en, req1_tag,
    input  req1_ready,
    input  res_valid, res_data, res_tag, res_src,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_src1, req0_src2, req0_shamt, req0_shamt_en, req0_tag,
    output req0_ready,
    input  req1_valid, req1_op, req1_src1, req1_src2, req1_shamt, req1_shamt_en, req1_tag,
    output req1_ready,
    output res_valid, res_data, res_tag, res_src,
    input  res_ready
  );
endinterface
`default_nettype wire

// File: rtl/ex_shift_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// ex_shift_arbiter : round-robin shared SLL/SRL/SRA unit, 1-entry result reg
// Rev 1.0
// ----------------------------------------------------------------------
module ex_shift_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SH_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  ex_shift_arbiter_if.slave bus
);

  logic                    r_res_valid;
  logic [XLEN-1:0]         r_res_data;
  logic [TAG_W-1:0]        r_res_tag;
  logic                    r_res_src;
  logic                    r_last_grant;

  logic                    w_free;
  logic                    w_can_accept;
  logic                    w_gnt0;
  logic                    w_gnt1;
  logic                    w_ready0;
  logic                    w_ready1;
  logic                    w_accept;
  logic                    w_sel;
  logic [2:0]              w_op;
  logic [XLEN-1:0]         w_src1;
  logic [SH_W-1:0]         w_src2_lo;
  logic [SH_W-1:0]         w_shamt;
  logic                    w_shamt_en;
  logic [TAG_W-1:0]        w_tag;
  logic [SH_W-1:0]         w_amt;
  logic signed [XLEN-1:0]  w_sra;
  logic [XLEN-1:0]         w_result;

  assign w_free       = !r_res_valid || bus.res_ready;
  assign w_can_accept = w_free && !flush && !rst;

  // Under contention the requester that did not win last time is served.
  assign w_gnt0   = bus.req0_valid && (!bus.req1_valid || r_last_grant);
  assign w_gnt1   = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
  assign w_ready0 = w_can_accept && w_gnt0;
  assign w_ready1 = w_can_accept && w_gnt1;
  assign w_accept = w_ready0 || w_ready1;
  assign w_sel    = w_gnt1;

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;

  always_comb begin
    w_op       = bus.req0_op;
    w_src1     = bus.req0_src1;
    w_src2_lo  = bus.req0_src2[SH_W-1:0];
    w_shamt    = bus.req0_shamt;
    w_shamt_en = bus.req0_shamt_en;
    w_tag      = bus.req0_tag;
    if (w_sel) begin
      w_op       = bus.req1_op;
      w_src1     = bus.req1_src1;
      w_src2_lo  = bus.req1_src2[SH_W-1:0];
      w_shamt    = bus.req1_shamt;
      w_shamt_en = bus.req1_shamt_en;
      w_tag      = bus.req1_tag;
    end
  end

  // Register and immediate amounts are ORed; decode zeroes src2 for immediates.
  assign w_amt = w_src2_lo | (w_shamt & {SH_W{w_shamt_en}});
  assign w_sra = $signed(w_src1) >>> w_amt;

  always_comb begin
    w_result = '0;
    if (w_op[0]) w_result = w_result | (w_src1 << w_amt);
    if (w_op[1]) w_result = w_result | (w_src1 >> w_amt);
    if (w_op[2]) w_result = w_result | w_sra;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_tag    <= '0;
      r_res_src    <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (flush) begin
      r_res_valid  <= 1'b0;
    end else if (w_accept) begin
      r_res_valid  <= 1'b1;
      r_res_data   <= w_result;
      r_res_tag    <= w_tag;
      r_res_src    <= w_sel;
      r_last_grant <= w_sel;
    end else if (bus.res_ready) begin
      r_res_valid  <= 1'b0;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_tag   = r_res_tag;
  assign bus.res_src   = r_res_src;

endmodule
`default_nettype wire

// File: tb/tb_ex_shift_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_ex_shift_arbiter : directed vectors, arbitration model, result scoreboard
// Rev 1.0
// ----------------------------------------------------------------------
module tb_ex_shift_arbiter;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic        shen;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        src;
  } res_t;

  logic clk;
  logic rst;
  logic flush;

  ex_shift_arbiter_if #(.XLEN(32), .TAG_W(5), .SH_W(5)) bus ();

  ex_shift_arbiter #(.XLEN(32), .TAG_W(5), .SH_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t q0[$];
  vec_t q1[$];
  res_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic m_valid = 1'b0;
  logic m_last  = 1'b1;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] src1,
                              input logic [31:0] src2, input logic [4:0] shamt,
                              input logic shen, input logic [4:0] tag,
                              input logic [31:0] exp);
    vec_t v;
    v.op = op; v.src1 = src1; v.src2 = src2; v.shamt = shamt;
    v.shen = shen; v.tag = tag; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    vec_t z;
    z = mk(3'b000, 32'h0, 32'h0, 5'h0, 1'b0, 5'h0, 32'h0);
    bus.req0_valid = (q0.size() != 0);
    bus.req1_valid = (q1.size() != 0);
    if (q0.size() != 0) z = q0[0];
    bus.req0_op = z.op; bus.req0_src1 = z.src1; bus.req0_src2 = z.src2;
    bus.req0_shamt = z.shamt; bus.req0_shamt_en = z.shen; bus.req0_tag = z.tag;
    z = mk(3'b000, 32'h0, 32'h0, 5'h0, 1'b0, 5'h0, 32'h0);
    if (q1.size() != 0) z = q1[0];
    bus.req1_op = z.op; bus.req1_src1 = z.src1; bus.req1_src2 = z.src2;
    bus.req1_shamt = z.shamt; bus.req1_shamt_en = z.shen; bus.req1_tag = z.tag;
  endtask

  // One cycle: drive, check readies/valid against the arbitration model, advance.
  task automatic step();
    logic acc, g0, g1, e0, e1;
    res_t r;
    drive();
    @(negedge clk);
    acc = (!m_valid || bus.res_ready) && !flush && !rst;
    g0  = bus.req0_valid && (!bus.req1_valid || m_last);
    g1  = bus.req1_valid && (!bus.req0_valid || !m_last);
    e0  = acc && g0;
    e1  = acc && g1;
    chk("req0_ready", {31'b0, bus.req0_ready}, {31'b0, e0});
    chk("req1_ready", {31'b0, bus.req1_ready}, {31'b0, e1});
    chk("res_valid",  {31'b0, bus.res_valid},  {31'b0, m_valid});
    if (rst) begin
      m_valid = 1'b0;
      m_last  = 1'b1;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (e0 || e1) begin
      m_valid = 1'b1;
      m_last  = e1;
      if (e0) begin
        r.data = q0[0].exp; r.tag = q0[0].tag; r.src = 1'b0;
        void'(q0.pop_front());
      end else begin
        r.data = q1[0].exp; r.tag = q1[0].tag; r.src = 1'b1;
        void'(q1.pop_front());
      end
      sb.push_back(r);
    end else if (bus.res_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int max);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_valid) && n < max) begin
      step();
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || m_valid) begin
      errors++;
      $display("FAIL run_timeout: pending q0=%0d q1=%0d valid=%0b after %0d cycles",
               q0.size(), q1.size(), m_valid, n);
    end
  endtask

  // Monitor: held results must match the scoreboard head; pop on take or discard.
  always @(negedge clk) begin
    if (bus.res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got data %h tag %h with empty scoreboard",
                 bus.res_data, bus.res_tag);
      end else if (rst || flush) begin
        void'(sb.pop_front());
      end else begin
        chk("res_data", bus.res_data, sb[0].data);
        chk("res_tag",  {27'b0, bus.res_tag}, {27'b0, sb[0].tag});
        chk("res_src",  {31'b0, bus.res_src}, {31'b0, sb[0].src});
        if (bus.res_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.res_ready = 1'b1;
    drive();
    @(posedge clk);
    #1;

    // Reset with a pending request: no acceptance, outputs cleared.
    q0.push_back(mk(3'b001, 32'h0000_0001, 32'd4, 5'd0, 1'b0, 5'd3, 32'h0000_0010));
    step();
    chk("reset_data", bus.res_data, 32'h0);
    chk("reset_tag",  {27'b0, bus.res_tag}, 32'h0);
    chk("reset_src",  {31'b0, bus.res_src}, 32'h0);
    rst = 1'b0;
    run(10);

    // Immediate SRA/SRL on requester 1.
    q1.push_back(mk(3'b100, 32'h8000_0000, 32'd0, 5'd31, 1'b1, 5'd7, 32'hFFFF_FFFF));
    q1.push_back(mk(3'b010, 32'h8000_0000, 32'd0, 5'd31, 1'b1, 5'd8, 32'h0000_0001));
    run(10);

    // Contention: grants alternate 0,1,0,1.
    q0.push_back(mk(3'b001, 32'h0000_0003, 32'd1, 5'd0, 1'b0, 5'd10, 32'h0000_0006));
    q0.push_back(mk(3'b010, 32'h0000_00F0, 32'd4, 5'd0, 1'b0, 5'd11, 32'h0000_000F));
    q1.push_back(mk(3'b100, 32'hFFFF_FF00, 32'd4, 5'd0, 1'b0, 5'd20, 32'hFFFF_FFF0));
    q1.push_back(mk(3'b001, 32'h0000_0001, 32'd0, 5'd31, 1'b1, 5'd21, 32'h8000_0000));
    run(12);

    // Backpressure: hold a result for 3 cycles, then drain-and-accept.
    q0.push_back(mk(3'b001, 32'h0000_0005, 32'd2, 5'd0, 1'b0, 5'd12, 32'h0000_0014));
    step();
    bus.res_ready = 1'b0;
    q0.push_back(mk(3'b100, 32'h7FFF_FFFF, 32'd31, 5'd0, 1'b0, 5'd13, 32'h0000_0000));
    q1.push_back(mk(3'b010, 32'h0000_0100, 32'd8, 5'd0, 1'b0, 5'd22, 32'h0000_0001));
    for (int i = 0; i < 3; i++) step();
    bus.res_ready = 1'b1;
    run(12);

    // Flush with a held result and pending requests; pointer survives the flush.
    q1.push_back(mk(3'b001, 32'h0000_0002, 32'd1, 5'd0, 1'b0, 5'd23, 32'h0000_0004));
    step();
    q0.push_back(mk(3'b010, 32'h0000_0008, 32'd3, 5'd0, 1'b0, 5'd15, 32'h0000_0001));
    q1.push_back(mk(3'b100, 32'h8000_0010, 32'd4, 5'd0, 1'b0, 5'd24, 32'hF800_0001));
    flush = 1'b1;
    step();
    flush = 1'b0;
    run(12);

    // Amount OR/masking, null op, multi-hot op.
    q0.push_back(mk(3'b001, 32'h0000_0001, 32'h0000_0123, 5'd4, 1'b1, 5'd16, 32'h0000_0080));
    q0.push_back(mk(3'b000, 32'hDEAD_BEEF, 32'd3, 5'd0, 1'b0, 5'd17, 32'h0000_0000));
    q0.push_back(mk(3'b011, 32'h0000_00F0, 32'd4, 5'd0, 1'b0, 5'd18, 32'h0000_0F0F));
    run(12);

    // Reset mid-operation returns the pointer to requester 1 as last grant.
    q0.push_back(mk(3'b010, 32'h0000_0010, 32'd4, 5'd0, 1'b0, 5'd19, 32'h0000_0001));
    step();
    q0.push_back(mk(3'b001, 32'hAAAA_5555, 32'h0000_0020, 5'd0, 1'b0, 5'd25, 32'hAAAA_5555));
    q1.push_back(mk(3'b100, 32'h4000_0000, 32'd30, 5'd0, 1'b0, 5'd26, 32'h0000_0001));
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(12);

    step();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_shift_arbiter.md
Name: ex_shift_arbiter

Overview:
- Shares the single execute-stage shift datapath (SLL/SRL/SRA) between two issue requesters.
- Round-robin arbitration picks one requester per cycle. The shift is computed and captured in a one-entry output register carrying the requester's tag.
- Sits between the two dispatch slots and the writeback/bypass mux. Valid/ready handshake on every side; supports pipeline flush.

Parameters:
- XLEN, 32, operand and result width.
- TAG_W, 5, width of the destination tag carried with each operation.
- SH_W, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discards the held result and blocks acceptance this cycle.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle (valid&ready).
- req0_op  input  3  one-hot op: bit0 SLL, bit1 SRL, bit2 SRA.
- req0_src1  input  XLEN  value to shift.
- req0_src2  input  XLEN  register shift amount; only [SH_W-1:0] used.
- req0_shamt  input  SH_W  immediate shift amount.
- req0_shamt_en  input  1  immediate form.
- req0_tag  input  TAG_W  destination tag.
- req1_valid, req1_ready, req1_op, req1_src1, req1_src2, req1_shamt, req1_shamt_en, req1_tag: same as requester 0.
- res_valid  output  1  result register holds a result.
- res_ready  input  1  consumer takes result this cycle.
- res_data  output  XLEN  shift result.
- res_tag  output  TAG_W  tag of the result.
- res_src  output  1  requester that issued the result (0/1).

Behaviour:
- Reset (rst=1 at edge):
  - res_valid=0, res_data=0, res_tag=0, res_src=0.
  - Round-robin pointer last_grant=1, so requester 0 has priority first.
  - req*_ready=0 during the reset cycle.
- Slot free:
  - free = !res_valid | res_ready.
  - Acceptance occurs only when free && !flush && !rst.
- Grant:
  - One requester valid: that requester wins.
  - Both valid: the one not equal to last_grant wins.
  - req_ready is combinational: asserted only for the winner when acceptance is possible; at most one ready per cycle.
  - last_grant updates only on an actual accept.
- Shift amount:
  - amt = src2[SH_W-1:0] | (shamt & {SH_W{shamt_en}}).
  - The OR is intentional. Decode drives src2=0 for immediate forms.
- Result:
  - Bitwise OR of (src1<<amt) if op[0], (src1>>amt) if op[1], and arithmetic (src1>>>amt) if op[2].
  - op=000 yields 0 and is still accepted, returning a tagged zero.
  - Multi-hot ops OR their results; this is not flagged.
- Latency: accept at edge N gives res_valid=1 with data/tag/src after edge N. Fixed 1 cycle; throughput 1 per cycle with res_ready held high.
- Backpressure: while res_valid && !res_ready, res_data/res_tag/res_src are held stable and both readies are 0.
- Simultaneous drain and accept (res_valid && res_ready && grant): the register loads the new result and res_valid stays 1, with no bubble.
- Drain without new grant: res_valid becomes 0. Data/tag are don't-care but hold their previous value.
- Flush:
  - Clears res_valid at the edge.
  - No acceptance that cycle even if requesters are valid.
  - last_grant is unchanged.
  - Flush has priority over res_ready.
- Reset mid-operation: same as flush plus the pointer returns to 1. Pending requests are re-presented by their owners.
- Fairness: under continuous contention, grants strictly alternate, so neither requester waits more than one accepted slot.

Test Plan:
- Reset then req0 only: op=001, src1=0x0000_0001, src2=4, res_ready=1 → req0_ready=1 in cycle 0; next cycle res_valid=1, res_data=0x0000_0010, res_src=0, tag echoed.
- SRA immediate on req1: src1=0x8000_0000, shamt=31, shamt_en=1, src2=0, op=100 → res_data=0xFFFF_FFFF. The same with op=010 → 0x0000_0001.
- Contention: both valid for 4 cycles, res_ready=1 → grant order 0,1,0,1; res_valid continuously 1; tags match in order.
- Backpressure: a result held with res_ready=0 for 3 cycles while both requesters are valid → both readies 0; res_data/res_tag stable. res_ready=1 → drain and accept in the same cycle with no bubble.
- Flush with res_valid=1 and req0_valid=1 → next cycle res_valid=0, no accept that cycle; the following cycle req0 accepted, with last_grant unchanged from before the flush.
- Amount masking/OR: src2=0x0000_0123 (low 5 bits = 3), shamt=4, shamt_en=1, op=001, src1=1 → amt=7, res_data=0x80. op=000 → res_data=0, still tagged valid.
